// File: rtl/div_sched_pkg.sv
// Shared types and constants for the time-multiplexed divider scheduler.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package div_sched_pkg;

    localparam int DIVIDEND_W = 32;
    localparam int DIVISOR_W  = 16;
    localparam int ITER_LAST  = 31;
    localparam int CNT_W      = 5;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        ITER = 2'd1,
        FIX  = 2'd2,
        RESP = 2'd3
    } state_t;

endpackage

// File: rtl/div_nr_step.sv
// One non-restoring division iteration: shift {rem,quo}, add/sub divisor, set quotient bit.
// Latency: combinational.
// Backpressure: none; the scheduler decides when the result is registered.
module div_nr_step
    import div_sched_pkg::*;
(
    input  logic [DIVIDEND_W-1:0] rem,
    input  logic [DIVIDEND_W-1:0] quo,
    input  logic [DIVISOR_W-1:0]  b,
    output logic [DIVIDEND_W-1:0] rem_nxt,
    output logic [DIVIDEND_W-1:0] quo_nxt
);

    logic [DIVIDEND_W-1:0] rem_sh;
    logic [DIVIDEND_W-1:0] b_ext;

    // Shift the pair left, then move the partial remainder toward zero by one divisor.
    always_comb begin
        b_ext   = {{(DIVIDEND_W-DIVISOR_W){1'b0}}, b};
        rem_sh  = {rem[DIVIDEND_W-2:0], quo[DIVIDEND_W-1]};
        if (rem_sh[DIVIDEND_W-1]) begin
            rem_nxt = rem_sh + b_ext;
        end else begin
            rem_nxt = rem_sh - b_ext;
        end
        quo_nxt = {quo[DIVIDEND_W-2:0], ~rem_nxt[DIVIDEND_W-1]};
    end

endmodule

// File: rtl/div_share_sched.sv
// Round-robin scheduler sharing one bit-serial 32/16 divider; optional B==0 shortcut under DIV_ZERO_DETECT_EN.
// Latency: 34 cycles from transfer edge to resp_valid (1 cycle for B==0 with DIV_ZERO_DETECT_EN).
// Backpressure: response held stable while resp_ready low; req_ready stays 0 until the response is taken.
module div_share_sched
    import div_sched_pkg::*;
#(
    parameter int NUM_REQ = 4,
    parameter int ID_W    = $clog2(NUM_REQ)
) (
    input  logic                            clk,
    input  logic                            rst,
    input  logic [NUM_REQ-1:0]              req_valid,
    input  logic [NUM_REQ*DIVIDEND_W-1:0]   req_a,
    input  logic [NUM_REQ*DIVISOR_W-1:0]    req_b,
    output logic [NUM_REQ-1:0]              req_ready,
    output logic                            resp_valid,
    input  logic                            resp_ready,
    output logic [ID_W-1:0]                 resp_id,
    output logic [DIVIDEND_W-1:0]           resp_quotient,
    output logic [DIVIDEND_W-1:0]           resp_remainder,
    output logic                            resp_dz,
    output logic                            busy
);

    state_t                 state_q, state_d;
    logic [ID_W-1:0]        last_grant_q, last_grant_d;
    logic [ID_W-1:0]        id_q, id_d;
    logic [DIVISOR_W-1:0]   b_q, b_d;
    logic [DIVIDEND_W-1:0]  rem_q, rem_d;
    logic [DIVIDEND_W-1:0]  quo_q, quo_d;
    logic [CNT_W-1:0]       cnt_q, cnt_d;
    logic                   resp_valid_q, resp_valid_d;
    logic [ID_W-1:0]        resp_id_q, resp_id_d;
    logic [DIVIDEND_W-1:0]  resp_quotient_q, resp_quotient_d;
    logic [DIVIDEND_W-1:0]  resp_remainder_q, resp_remainder_d;
    logic                   resp_dz_q, resp_dz_d;

    logic                   found;
    logic [ID_W-1:0]        grant_idx;
    logic [NUM_REQ-1:0]     grant;
    logic [DIVIDEND_W-1:0]  a_sel;
    logic [DIVISOR_W-1:0]   b_sel;
    logic [DIVIDEND_W-1:0]  step_rem;
    logic [DIVIDEND_W-1:0]  step_quo;

    // Requester index k positions after base, wrapping at NUM_REQ (which need not be a power of two).
    function automatic logic [ID_W-1:0] rr_idx(input logic [ID_W-1:0] base, input int k);
        int s;
        s = int'(base) + k;
        if (s >= NUM_REQ) begin
            s = s - NUM_REQ;
        end
        return ID_W'(s);
    endfunction

    div_nr_step u_step (
        .rem     (rem_q),
        .quo     (quo_q),
        .b       (b_q),
        .rem_nxt (step_rem),
        .quo_nxt (step_quo)
    );

    // Round-robin pick: first valid requester after the last granted one.
    always_comb begin
        found     = 1'b0;
        grant_idx = '0;
        grant     = '0;
        for (int k = 1; k <= NUM_REQ; k++) begin
            if (!found && req_valid[rr_idx(last_grant_q, k)]) begin
                found     = 1'b1;
                grant_idx = rr_idx(last_grant_q, k);
            end
        end
        if (found) begin
            grant[grant_idx] = 1'b1;
        end
        a_sel = req_a[int'(grant_idx)*DIVIDEND_W +: DIVIDEND_W];
        b_sel = req_b[int'(grant_idx)*DIVISOR_W +: DIVISOR_W];
    end

    assign req_ready      = (state_q == IDLE) ? grant : '0;
    assign busy           = (state_q != IDLE);
    assign resp_valid     = resp_valid_q;
    assign resp_id        = resp_id_q;
    assign resp_quotient  = resp_quotient_q;
    assign resp_remainder = resp_remainder_q;
    assign resp_dz        = resp_dz_q;

    // Sequencer: accept, iterate 32 times, correct the remainder, present the response.
    always_comb begin
        state_d          = state_q;
        last_grant_d     = last_grant_q;
        id_d             = id_q;
        b_d              = b_q;
        rem_d            = rem_q;
        quo_d            = quo_q;
        cnt_d            = cnt_q;
        resp_valid_d     = resp_valid_q;
        resp_id_d        = resp_id_q;
        resp_quotient_d  = resp_quotient_q;
        resp_remainder_d = resp_remainder_q;
        resp_dz_d        = resp_dz_q;
        case (state_q)
            IDLE: begin
                if (found) begin
                    last_grant_d = grant_idx;
                    id_d         = grant_idx;
                    b_d          = b_sel;
                    rem_d        = '0;
                    quo_d        = a_sel;
                    cnt_d        = '0;
                    state_d      = ITER;
`ifdef DIV_ZERO_DETECT_EN
                    // Zero divisor: answer immediately without touching the datapath.
                    if (b_sel == '0) begin
                        state_d          = RESP;
                        resp_valid_d     = 1'b1;
                        resp_id_d        = grant_idx;
                        resp_quotient_d  = '1;
                        resp_remainder_d = a_sel;
                        resp_dz_d        = 1'b1;
                    end
`endif
                end
            end
            ITER: begin
                rem_d = step_rem;
                quo_d = step_quo;
                cnt_d = cnt_q + CNT_W'(1);
                if (cnt_q == CNT_W'(ITER_LAST)) begin
                    state_d = FIX;
                end
            end
            FIX: begin
                // A negative partial remainder is brought back into [0, B).
                if (rem_q[DIVIDEND_W-1]) begin
                    resp_remainder_d = rem_q + {{(DIVIDEND_W-DIVISOR_W){1'b0}}, b_q};
                end else begin
                    resp_remainder_d = rem_q;
                end
                resp_valid_d    = 1'b1;
                resp_id_d       = id_q;
                resp_quotient_d = quo_q;
                resp_dz_d       = 1'b0;
                state_d         = RESP;
            end
            RESP: begin
                if (resp_ready) begin
                    resp_valid_d = 1'b0;
                    state_d      = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // Control state; reset discards any division in flight and makes requester 0 win first.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q      <= IDLE;
            last_grant_q <= ID_W'(NUM_REQ - 1);
            id_q         <= '0;
            cnt_q        <= '0;
        end else begin
            state_q      <= state_d;
            last_grant_q <= last_grant_d;
            id_q         <= id_d;
            cnt_q        <= cnt_d;
        end
    end

    // Divider working registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            b_q   <= '0;
            rem_q <= '0;
            quo_q <= '0;
        end else begin
            b_q   <= b_d;
            rem_q <= rem_d;
            quo_q <= quo_d;
        end
    end

    // Registered response port.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            resp_valid_q     <= 1'b0;
            resp_id_q        <= '0;
            resp_quotient_q  <= '0;
            resp_remainder_q <= '0;
            resp_dz_q        <= 1'b0;
        end else begin
            resp_valid_q     <= resp_valid_d;
            resp_id_q        <= resp_id_d;
            resp_quotient_q  <= resp_quotient_d;
            resp_remainder_q <= resp_remainder_d;
            resp_dz_q        <= resp_dz_d;
        end
    end

endmodule

// File: tb/tb_div_share_sched.sv
// Bench for div_share_sched: table of single divisions plus contention, back-pressure and reset sequences.
// Inputs change only just after a rising edge; outputs are sampled on the falling edge.
// A monitor scoreboard checks every response against a reference division model.
module tb_div_share_sched;

    localparam int NUM_REQ = 4;
    localparam int ID_W    = 2;

    logic                    clk;
    logic                    rst;
    logic [NUM_REQ-1:0]      req_valid;
    logic [NUM_REQ*32-1:0]   req_a;
    logic [NUM_REQ*16-1:0]   req_b;
    logic [NUM_REQ-1:0]      req_ready;
    logic                    resp_valid;
    logic                    resp_ready;
    logic [ID_W-1:0]         resp_id;
    logic [31:0]             resp_quotient;
    logic [31:0]             resp_remainder;
    logic                    resp_dz;
    logic                    busy;

    div_share_sched #(.NUM_REQ(NUM_REQ)) dut (
        .clk            (clk),
        .rst            (rst),
        .req_valid      (req_valid),
        .req_a          (req_a),
        .req_b          (req_b),
        .req_ready      (req_ready),
        .resp_valid     (resp_valid),
        .resp_ready     (resp_ready),
        .resp_id        (resp_id),
        .resp_quotient  (resp_quotient),
        .resp_remainder (resp_remainder),
        .resp_dz        (resp_dz),
        .busy           (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int tests = 0;
    int fails = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Scoreboard fed by the monitor on every observed transfer.
    typedef struct packed {
        logic [ID_W-1:0] id;
        logic [31:0]     q;
        logic [31:0]     r;
        logic            dz;
    } exp_t;

    exp_t        sb[$];
    int          grant_log[$];
    exp_t        mon_e;
    exp_t        mon_g;
    logic [31:0] mon_a;
    logic [15:0] mon_b;

    always @(negedge clk) begin
        if (!rst) begin
            if (req_valid != '0) begin
                chk("req_ready_onehot", 64'($countones(req_ready) <= 1), 64'd1);
            end
            for (int i = 0; i < NUM_REQ; i++) begin
                if (req_valid[i] && req_ready[i]) begin
                    mon_a   = req_a[i*32 +: 32];
                    mon_b   = req_b[i*16 +: 16];
                    mon_e.id = ID_W'(i);
                    if (mon_b == 16'd0) begin
                        mon_e.q = 32'hFFFF_FFFF;
                        mon_e.r = mon_a;
                    end else begin
                        mon_e.q = mon_a / {16'd0, mon_b};
                        mon_e.r = mon_a % {16'd0, mon_b};
                    end
`ifdef DIV_ZERO_DETECT_EN
                    mon_e.dz = (mon_b == 16'd0);
`else
                    mon_e.dz = 1'b0;
`endif
                    sb.push_back(mon_e);
                    grant_log.push_back(i);
                end
            end
            if (resp_valid && resp_ready) begin
                if (sb.size() == 0) begin
                    chk("unexpected_resp", 64'd1, 64'd0);
                end else begin
                    mon_g = sb.pop_front();
                    chk("sb_id", 64'(resp_id), 64'(mon_g.id));
                    chk("sb_quotient", 64'(resp_quotient), 64'(mon_g.q));
                    chk("sb_remainder", 64'(resp_remainder), 64'(mon_g.r));
                    chk("sb_dz", 64'(resp_dz), 64'(mon_g.dz));
                end
            end
        end
    end

    // Present a request, wait (bounded) for its grant, then withdraw and scramble the operands.
    task automatic start(input int id, input logic [31:0] a, input logic [15:0] b);
        int n;
        @(posedge clk); #1;
        req_a[id*32 +: 32] = a;
        req_b[id*16 +: 16] = b;
        req_valid[id]      = 1'b1;
        n = 0;
        @(negedge clk);
        while (!req_ready[id] && n < 100) begin
            @(negedge clk);
            n++;
        end
        chk("grant", 64'(req_ready[id]), 64'd1);
        @(posedge clk); #1;
        req_valid[id]      = 1'b0;
        req_a[id*32 +: 32] = $urandom;
        req_b[id*16 +: 16] = 16'($urandom);
    endtask

    // Cycles from the transfer edge to the first cycle showing resp_valid.
    task automatic wait_resp(output int lat);
        lat = 1;
        @(negedge clk);
        while (!resp_valid && lat < 200) begin
            @(negedge clk);
            lat++;
        end
    endtask

    task automatic drain();
        int n;
        n = 0;
        while ((sb.size() != 0 || resp_valid) && n < 200) begin
            @(negedge clk);
            n++;
        end
        chk("sb_drain", 64'(sb.size()), 64'd0);
    endtask

    typedef struct {
        int          id;
        logic [31:0] a;
        logic [15:0] b;
        logic [31:0] q;
        logic [31:0] r;
    } vec_t;

    vec_t vecs[8];

    initial begin
        int   lat;
        int   exp_lat;
        logic exp_dz;
        bit   seen;

        rst        = 1'b1;
        req_valid  = '0;
        req_a      = '0;
        req_b      = '0;
        resp_ready = 1'b1;

        vecs[0] = '{2, 32'd100,        16'd7,      32'd14,         32'd2};
        vecs[1] = '{0, 32'hFFFF_FFFF,  16'hFFFF,   32'h0001_0001,  32'd0};
        vecs[2] = '{1, 32'd5,          16'd9,      32'd0,          32'd5};
        vecs[3] = '{3, 32'h1234_5678,  16'h0010,   32'h0123_4567,  32'd8};
        vecs[4] = '{2, 32'hFFFF_FFFF,  16'h0002,   32'h7FFF_FFFF,  32'd1};
        vecs[5] = '{1, 32'h8000_0000,  16'h0001,   32'h8000_0000,  32'd0};
        vecs[6] = '{0, 32'd1000000,    16'd3,      32'd333333,     32'd1};
        vecs[7] = '{3, 32'd123,        16'd0,      32'hFFFF_FFFF,  32'd123};

        // Reset state.
        #3;
        chk("rst_resp_valid", 64'(resp_valid), 64'd0);
        chk("rst_busy", 64'(busy), 64'd0);
        chk("rst_req_ready", 64'(req_ready), 64'd0);
        chk("rst_resp_id", 64'(resp_id), 64'd0);
        chk("rst_quotient", 64'(resp_quotient), 64'd0);
        chk("rst_remainder", 64'(resp_remainder), 64'd0);
        chk("rst_dz", 64'(resp_dz), 64'd0);
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;

        // Table of single divisions.
        for (int v = 0; v < 8; v++) begin
            exp_lat = 34;
            exp_dz  = 1'b0;
`ifdef DIV_ZERO_DETECT_EN
            if (vecs[v].b == 16'd0) begin
                exp_lat = 1;
                exp_dz  = 1'b1;
            end
`endif
            start(vecs[v].id, vecs[v].a, vecs[v].b);
            wait_resp(lat);
            chk("vec_latency", 64'(lat), 64'(exp_lat));
            chk("vec_id", 64'(resp_id), 64'(vecs[v].id));
            chk("vec_quotient", 64'(resp_quotient), 64'(vecs[v].q));
            chk("vec_remainder", 64'(resp_remainder), 64'(vecs[v].r));
            chk("vec_dz", 64'(resp_dz), 64'(exp_dz));
            chk("vec_busy", 64'(busy), 64'd1);
        end
        drain();

        // Contention: all requesters valid from reset.
        @(posedge clk); #1;
        rst = 1'b1;
        sb.delete();
        grant_log.delete();
        for (int i = 0; i < NUM_REQ; i++) begin
            req_a[i*32 +: 32] = 32'h1000_0000 * i + 32'd12345;
            req_b[i*16 +: 16] = 16'(i * 1000 + 3);
        end
        req_valid = '1;
        @(posedge clk); #1;
        rst = 1'b0;
        begin
            int n;
            n = 0;
            while (grant_log.size() < 5 && n < 400) begin
                @(negedge clk);
                n++;
            end
        end
        @(posedge clk); #1;
        req_valid = '0;
        chk("cont_grants", 64'(grant_log.size()), 64'd5);
        if (grant_log.size() >= 5) begin
            chk("cont_g0", 64'(grant_log[0]), 64'd0);
            chk("cont_g1", 64'(grant_log[1]), 64'd1);
            chk("cont_g2", 64'(grant_log[2]), 64'd2);
            chk("cont_g3", 64'(grant_log[3]), 64'd3);
            chk("cont_g4", 64'(grant_log[4]), 64'd0);
        end
        drain();

        // Back-pressure: response held while resp_ready is low.
        @(posedge clk); #1;
        resp_ready = 1'b0;
        start(2, 32'd1000, 16'd7);
        wait_resp(lat);
        chk("bp_latency", 64'(lat), 64'd34);
        @(posedge clk); #1;
        req_a[1*32 +: 32] = 32'd77;
        req_b[1*16 +: 16] = 16'd5;
        req_valid[1]      = 1'b1;
        for (int c = 0; c < 10; c++) begin
            @(negedge clk);
            chk("bp_valid", 64'(resp_valid), 64'd1);
            chk("bp_quotient", 64'(resp_quotient), 64'd142);
            chk("bp_remainder", 64'(resp_remainder), 64'd6);
            chk("bp_id", 64'(resp_id), 64'd2);
            chk("bp_req_ready", 64'(req_ready), 64'd0);
        end
        @(posedge clk); #1;
        resp_ready = 1'b1;
        @(posedge clk); #1;
        @(negedge clk);
        chk("bp_after_valid", 64'(resp_valid), 64'd0);
        chk("bp_after_busy", 64'(busy), 64'd0);
        chk("bp_after_grant", 64'(req_ready), 64'b0010);
        @(posedge clk); #1;
        req_valid[1] = 1'b0;
        drain();

        // Reset in the middle of a division.
        start(2, 32'd5000, 16'd13);
        repeat (9) @(posedge clk);
        #1 rst = 1'b1;
        sb.delete();
        #1;
        chk("mid_rst_valid", 64'(resp_valid), 64'd0);
        chk("mid_rst_busy", 64'(busy), 64'd0);
        chk("mid_rst_id", 64'(resp_id), 64'd0);
        chk("mid_rst_quotient", 64'(resp_quotient), 64'd0);
        chk("mid_rst_remainder", 64'(resp_remainder), 64'd0);
        chk("mid_rst_dz", 64'(resp_dz), 64'd0);
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
        seen = 1'b0;
        for (int c = 0; c < 40; c++) begin
            @(negedge clk);
            if (resp_valid || busy) seen = 1'b1;
        end
        chk("mid_rst_no_resp", 64'(seen), 64'd0);
        @(posedge clk); #1;
        req_a[0*32 +: 32] = 32'd900;
        req_b[0*16 +: 16] = 16'd30;
        req_a[3*32 +: 32] = 32'd901;
        req_b[3*16 +: 16] = 16'd31;
        req_valid = 4'b1001;
        @(negedge clk);
        chk("post_rst_grant", 64'(req_ready), 64'b0001);
        @(posedge clk); #1;
        req_valid = '0;
        drain();

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
